// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART transmitter and receiver.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

   function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver with 2-flop synchroniser, mid-bit sampling and framing-error recovery.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rx_enable,
   output logic [7:0] rx_byte,
   output logic       byte_available
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2);

   uart_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      byte_q, byte_d;
   logic            avail_q, avail_d;
   logic            err_q, err_d;
   logic            sync1_q, sync2_q, prev_q;
   logic            rx_s;

   assign rx_s = sync2_q;

   // Synchroniser flops reset to the idle-high line level to avoid a false start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         byte_q  <= '0;
         avail_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         avail_q <= avail_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      avail_d = 1'b0;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (rx_enable && prev_q && !rx_s) begin
               cnt_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == CntHalf) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == CntLast) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            // After a framing error, hold here until the line returns high.
            if (err_q) begin
               if (rx_s) begin
                  err_d   = 1'b0;
                  state_d = IDLE;
               end
            end else if (cnt_q == CntLast) begin
               cnt_d = '0;
               if (rx_s) begin
                  byte_d  = shift_q;
                  avail_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rx_byte        = byte_q;
   assign byte_available = avail_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT clocks.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_byte,
   input  logic       tx_enable,
   output logic       tx,
   output logic       tx_busy
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

   uart_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      unique case (state_q)
         IDLE: begin
            if (tx_enable) begin
               shift_d = tx_byte;
               cnt_d   = '0;
               bit_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == CntLast) begin
               cnt_d   = '0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == CntLast) begin
               cnt_d   = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == CntLast) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level decoded straight from state so reset forces idle-high without a clock.
   always_comb begin
      tx = 1'b1;
      unique case (state_q)
         START:   tx = 1'b0;
         DATA:    tx = shift_q[0];
         default: tx = 1'b1;
      endcase
   end

   assign tx_busy = (state_q != IDLE);

endmodule

// File: rtl/uart_8n1.sv
// Full-duplex 8N1 UART top: independent transmitter and receiver on one clock.
module uart_8n1
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 12_000_000,
   parameter int unsigned BAUD   = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       tx,
   input  logic [7:0] tx_byte,
   input  logic       tx_enable,
   output logic       tx_busy,
   output logic [7:0] rx_byte,
   input  logic       rx_enable,
   output logic       byte_available
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

   uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk      (clk),
      .rst      (rst),
      .tx_byte  (tx_byte),
      .tx_enable(tx_enable),
      .tx       (tx),
      .tx_busy  (tx_busy)
   );

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk           (clk),
      .rst           (rst),
      .rx            (rx),
      .rx_enable     (rx_enable),
      .rx_byte       (rx_byte),
      .byte_available(byte_available)
   );

endmodule

// File: tb/tb_uart_8n1.sv
// Randomised self-checking bench for uart_8n1 against a frame-level reference model.
module tb_uart_8n1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx;
   logic       tx;
   logic [7:0] tx_byte = 8'h00;
   logic       tx_enable = 1'b0;
   logic       tx_busy;
   logic [7:0] rx_byte;
   logic       rx_enable = 1'b0;
   logic       byte_available;
   logic       rx_drv = 1'b1;
   logic       loop = 1'b0;

   assign rx = loop ? tx : rx_drv;

   always #5 clk = ~clk;

   uart_8n1 #(
      .CLK_HZ(1_000_000),
      .BAUD  (100_000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx            (rx),
      .tx            (tx),
      .tx_byte       (tx_byte),
      .tx_enable     (tx_enable),
      .tx_busy       (tx_busy),
      .rx_byte       (rx_byte),
      .rx_enable     (rx_enable),
      .byte_available(byte_available)
   );

   int          n_checks = 0;
   int          n_pass = 0;
   int unsigned cyc = 0;
   int unsigned strobe_cyc = 0;
   logic [7:0]  got_q[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  model_rx = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   // A strobe wider than one cycle shows up as duplicate received bytes.
   always @(negedge clk) begin
      if (byte_available === 1'b1) begin
         got_q.push_back(rx_byte);
         strobe_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_byte(input logic [7:0] b);
      exp_q.push_back(b);
      model_rx = b;
   endtask

   task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
      logic [9:0] f;
      f = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_drv = f[i];
         tick(10);
      end
      rx_drv = 1'b1;
   endtask

   task automatic check_rx(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0)
         check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
      got_q.delete();
      exp_q.delete();
      check({tag, "_rx_byte"}, rx_byte, model_rx);
   endtask

   // Sends one byte and checks every cycle of the expected 100-cycle waveform.
   task automatic send_tx(input logic [7:0] b, input logic poke);
      logic [9:0] f;
      int         bad_tx;
      int         bad_busy;
      f        = {1'b1, b, 1'b0};
      bad_tx   = 0;
      bad_busy = 0;
      tx_byte   = b;
      tx_enable = 1'b1;
      tick(1);
      tx_enable = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (tx !== f[c/10]) bad_tx++;
         if (tx_busy !== 1'b1) bad_busy++;
         tx_enable = poke && (c == 30);
         if (poke && c == 30) tx_byte = ~b;
         tick(1);
      end
      tx_enable = 1'b0;
      check("tx_wave_errs", bad_tx, 0);
      check("tx_busy_errs", bad_busy, 0);
      check("tx_busy_drop", tx_busy, 1'b0);
      check("tx_idle", tx, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0]  b;
      logic        en;
      logic        stop_ok;
      int unsigned s;

      tick(3);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", tx_busy, 1'b0);
      check("rst_rx_byte", rx_byte, 8'h00);
      check("rst_avail", byte_available, 1'b0);
      rst = 1'b0;
      tick(3);

      // Reset in the middle of a looped-back frame.
      loop      = 1'b1;
      rx_enable = 1'b1;
      tx_byte   = 8'hC3;
      tx_enable = 1'b1;
      tick(1);
      tx_enable = 1'b0;
      tick(25);
      check("mid_busy_before_rst", tx_busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_tx", tx, 1'b1);
      check("async_rst_busy", tx_busy, 1'b0);
      check("async_rst_avail", byte_available, 1'b0);
      tick(3);
      rst = 1'b0;
      tick(150);
      check_rx("rst_drop");

      b = 8'($urandom);
      send_tx(b, 1'b0);
      expect_byte(b);
      tick(20);
      check_rx("post_rst_frame");

      send_tx(8'h41, 1'b0);
      expect_byte(8'h41);
      tick(20);
      check_rx("tx_41");

      send_tx(8'h00, 1'b1);
      send_tx(8'hFF, 1'b0);
      expect_byte(8'h00);
      expect_byte(8'hFF);
      tick(20);
      check_rx("b2b");
      loop = 1'b0;
      tick(20);

      s = cyc;
      drive_frame(8'hA5, 1'b1);
      expect_byte(8'hA5);
      tick(5);
      check("a5_strobe_window", (strobe_cyc >= s + 96) && (strobe_cyc <= s + 102), 1'b1);
      check_rx("rx_a5");

      rx_drv = 1'b0;
      tick(3);
      rx_drv = 1'b1;
      tick(150);
      check_rx("glitch");

      rx_enable = 1'b0;
      drive_frame(8'h30, 1'b1);
      tick(20);
      check_rx("disabled");
      rx_enable = 1'b1;

      drive_frame(8'h55, 1'b0);
      tick(20);
      check_rx("framing_err");
      drive_frame(8'h31, 1'b1);
      expect_byte(8'h31);
      tick(20);
      check_rx("after_ferr");

      // Dropping rx_enable mid-frame must not abort that frame.
      b = 8'($urandom);
      fork
         drive_frame(b, 1'b1);
         begin
            tick(30);
            rx_enable = 1'b0;
         end
      join
      expect_byte(b);
      tick(20);
      check_rx("en_drop_mid");
      rx_enable = 1'b1;

      for (int i = 0; i < 6; i++) begin
         b         = 8'($urandom);
         en        = 1'($urandom_range(0, 1));
         stop_ok   = ($urandom_range(0, 3) != 0);
         rx_enable = en;
         drive_frame(b, stop_ok);
         tick(20);
         if (en && stop_ok) expect_byte(b);
         check_rx("rand_rx");
      end

      rx_enable = 1'b1;
      loop      = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         send_tx(b, 1'($urandom_range(0, 1)));
         expect_byte(b);
         tick(15);
         check_rx("rand_loop");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
